// File: rtl/bitcnt_unit.sv
// bitcnt_unit: two-stage pipelined CTZ / CLZ / CPOP with valid/ready handshakes.
// Stage 1 reduces the operand to per-nibble counts; stage 2 merges them into the
// final count. A tag travels alongside each operation untouched.
module bitcnt_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NIB  = int'(WIDTH) / 4;
    localparam int LVLS = $clog2(NIB);
    localparam int CW   = $clog2(WIDTH) + 1;

    localparam logic [1:0] OpClz = 2'b01;

    // Trailing zeros of one nibble; an all-zero nibble counts as 4.
    function automatic logic [2:0] nib_ctz(input logic [3:0] v);
        casez (v)
            4'b???1: return 3'd0;
            4'b??10: return 3'd1;
            4'b?100: return 3'd2;
            4'b1000: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] nib_pop(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [2:0]       s1_cnt_q [NIB];
    logic [2:0]       s1_cnt_d [NIB];
    logic [2:0]       nib_cnt  [NIB];

    // Stage 2 state (drives the outputs directly)
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [CW-1:0]    merged;

    logic s2_adv;

    // Handshake: in_ready is combinational from out_ready through s2_adv.
    assign s2_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;

    // Per-nibble counts of the incoming operand; CLZ is CTZ of the bit-reversed operand,
    // and op[1] set (CPOP and the reserved code) selects popcount.
    always_comb begin : s1_count
        logic [WIDTH-1:0] xs;
        xs = in_x;
        if (in_op == OpClz) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                xs[i] = in_x[int'(WIDTH) - 1 - i];
            end
        end
        for (int n = 0; n < NIB; n++) begin
            nib_cnt[n] = in_op[1] ? nib_pop(xs[4*n +: 4]) : nib_ctz(xs[4*n +: 4]);
        end
    end

    // Stage 1 next state: flush drops both the resident op and any op offered this cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s1_cnt_d   = s1_cnt_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = in_op;
                s1_tag_d = in_tag;
                s1_cnt_d = nib_cnt;
            end
        end
    end

    // Pairwise merge tree over the nibble counts (lower half at even index).
    always_comb begin : s2_merge
        logic [CW-1:0] tree [LVLS+1][NIB];
        logic [CW-1:0] lo, hi;
        for (int l = 0; l <= LVLS; l++) begin
            for (int n = 0; n < NIB; n++) begin
                tree[l][n] = '0;
            end
        end
        lo = '0;
        hi = '0;
        for (int n = 0; n < NIB; n++) begin
            tree[0][n] = CW'(s1_cnt_q[n]);
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int n = 0; n < (NIB >> (l + 1)); n++) begin
                lo = tree[l][2*n];
                hi = tree[l][2*n+1];
                if (s1_op_q[1]) begin
                    tree[l+1][n] = lo + hi;
                end else if (lo == CW'(4 << l)) begin
                    // Lower group is entirely zero: the count continues into the upper group.
                    tree[l+1][n] = CW'(4 << l) + hi;
                end else begin
                    tree[l+1][n] = lo;
                end
            end
        end
        merged = tree[LVLS][0];
    end

    // Stage 2 next state: load when the output slot is free or being consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_res_d = WIDTH'(merged);
                out_tag_d = s1_tag_q;
            end
        end
    end

    // Pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            for (int n = 0; n < NIB; n++) begin
                s1_cnt_q[n] <= '0;
            end
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_cnt_q    <= s1_cnt_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule
